// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : round-robin share of one memory port between I/D caches.
// Optional macro MEM_ARB_TIMEOUT_EN adds a BUSY watchdog with sticky o_err.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA       = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // port0 (I-cache)
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic [DATA_W-1:0] i_p0_data,
  input  logic              i_p0_rd,
  input  logic              i_p0_wr,
  output logic [DATA_W-1:0] o_p0_data,
  output logic              o_p0_ACK,
  // port1 (D-cache)
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic [DATA_W-1:0] i_p1_data,
  input  logic              i_p1_rd,
  input  logic              i_p1_wr,
  output logic [DATA_W-1:0] o_p1_data,
  output logic              o_p1_ACK,
  // memory side
  output logic [ADDR_W-1:0] o_addr_mem,
  output logic [DATA_W-1:0] o_data_mem,
  output logic              o_rd_mem,
  output logic              o_wr_mem,
  input  logic [DATA_W-1:0] i_data_mem,
  input  logic              i_ACK,
  output logic              o_busy,
  output logic              o_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              pend0;
  logic              pend1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              wr0;
  logic              wr1;

  logic              grant;       // 0 = port0, 1 = port1
  logic              grant_nxt;
  logic              last_served;

  logic              busy;
  logic              done;
  logic              at_limit;
  logic              timeout_hit;
  logic              req_on;

  logic [ADDR_W-1:0] addr_g;
  logic [DATA_W-1:0] data_g;
  logic              wr_g;

  logic              take0;
  logic              take1;
  logic              clr0;
  logic              clr1;

  assign busy   = (state == ST_BUSY);
  assign addr_g = grant ? addr1 : addr0;
  assign data_g = grant ? data1 : data0;
  assign wr_g   = grant ? wr1   : wr0;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] busy_cnt;
  logic             err;

  // Counter sits at zero in IDLE, so every BUSY entry starts from zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (!busy) begin
        busy_cnt <= '0;
      end else begin
        busy_cnt <= busy_cnt + 1'b1;
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end
    end
  end

  // Request lines drop at the limit regardless of i_ACK; a late i_ACK still
  // completes normally so no error is flagged in that case.
  assign at_limit    = busy && (busy_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign timeout_hit = at_limit && !i_ACK;
  assign o_err       = err;
`else
  assign at_limit    = 1'b0;
  assign timeout_hit = 1'b0;
  assign o_err       = 1'b0;
`endif

  assign done   = busy && (i_ACK || timeout_hit);
  assign req_on = busy && !at_limit;

  // Capture: a new pulse is accepted when the port is free, or in the very
  // cycle its previous transaction is acknowledged (set wins over clear).
  assign clr0  = done && !grant;
  assign clr1  = done &&  grant;
  assign take0 = (i_p0_rd || i_p0_wr) && (!pend0 || clr0);
  assign take1 = (i_p1_rd || i_p1_wr) && (!pend1 || clr1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend0 <= 1'b0;
      addr0 <= '0;
      data0 <= '0;
      wr0   <= 1'b0;
    end else begin
      if (take0) begin
        pend0 <= 1'b1;
        addr0 <= i_p0_addr;
        data0 <= i_p0_data;
        wr0   <= i_p0_wr;
      end else if (clr0) begin
        pend0 <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend1 <= 1'b0;
      addr1 <= '0;
      data1 <= '0;
      wr1   <= 1'b0;
    end else begin
      if (take1) begin
        pend1 <= 1'b1;
        addr1 <= i_p1_addr;
        data1 <= i_p1_data;
        wr1   <= i_p1_wr;
      end else if (clr1) begin
        pend1 <= 1'b0;
      end
    end
  end

  // last_served resets to port0 so port1 wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      grant       <= 1'b0;
      last_served <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (done) begin
        last_served <= grant;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      ST_IDLE: begin
        if (pend0 || pend1) begin
          state_nxt = ST_BUSY;
          if (pend0 && pend1) begin
            grant_nxt = ~last_served;
          end else begin
            grant_nxt = pend1;
          end
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_busy     = busy;
  assign o_addr_mem = req_on ? addr_g : '0;
  assign o_data_mem = req_on ? data_g : '0;
  assign o_rd_mem   = req_on && !wr_g;
  assign o_wr_mem   = req_on &&  wr_g;

  assign o_p0_ACK  = clr0;
  assign o_p1_ACK  = clr1;
  assign o_p0_data = clr0 ? (timeout_hit ? ERR_DATA : (wr_g ? '0 : i_data_mem)) : '0;
  assign o_p1_data = clr1 ? (timeout_hit ? ERR_DATA : (wr_g ? '0 : i_data_mem)) : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : directed scenarios plus randomized traffic checked
// against a transaction-level arbitration model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] p0_addr = '0, p0_data = '0, p1_addr = '0, p1_data = '0;
  logic        p0_rd = 1'b0, p0_wr = 1'b0, p1_rd = 1'b0, p1_wr = 1'b0;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_ack, p1_ack;
  logic [31:0] addr_mem, data_mem;
  logic        rd_mem, wr_mem;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_p0_addr(p0_addr), .i_p0_data(p0_data), .i_p0_rd(p0_rd), .i_p0_wr(p0_wr),
    .o_p0_data(p0_rdata), .o_p0_ACK(p0_ack),
    .i_p1_addr(p1_addr), .i_p1_data(p1_data), .i_p1_rd(p1_rd), .i_p1_wr(p1_wr),
    .o_p1_data(p1_rdata), .o_p1_ACK(p1_ack),
    .o_addr_mem(addr_mem), .o_data_mem(data_mem), .o_rd_mem(rd_mem), .o_wr_mem(wr_mem),
    .i_data_mem(mem_rdata), .i_ACK(mem_ack), .o_busy(busy), .o_err(err)
  );

  task automatic clear_inputs();
    p0_rd = 1'b0; p0_wr = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    mem_ack = 1'b1;
    #1;
    checks++;
    if ({busy, rd_mem, wr_mem, addr_mem, data_mem, p0_ack, p0_rdata, p1_ack, p1_rdata, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b rd=%b wr=%b addr=%h data=%h a0=%b a1=%b err=%b, required all 0",
               busy, rd_mem, wr_mem, addr_mem, data_mem, p0_ack, p1_ack, err);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    p0_rd = 1'b1; p0_addr = 32'h100;
    @(negedge clk);
    p0_rd = 1'b0; p0_addr = 32'hDEAD_0000;
    #1;
    checks++;
    if (rd_mem !== 1'b0) begin
      errors++; $display("FAIL single_n1_idle: rd_mem=%b required 0", rd_mem);
    end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001; end
      #1;
      checks++;
      if ({rd_mem, wr_mem, addr_mem} !== {1'b1, 1'b0, 32'h100}) begin
        errors++; $display("FAIL single_req_n%0d: rd=%b wr=%b addr=%h required 1 0 00000100", k, rd_mem, wr_mem, addr_mem);
      end
    end
    checks++;
    if ({p0_ack, p0_rdata, p1_ack} !== {1'b1, 32'hCAFE_0001, 1'b0}) begin
      errors++; $display("FAIL single_ack: ack0=%b data=%h ack1=%b required 1 cafe0001 0", p0_ack, p0_rdata, p1_ack);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({busy, rd_mem, addr_mem, p0_ack} !== '0) begin
      errors++; $display("FAIL single_after: busy=%b rd=%b addr=%h ack0=%b required all 0", busy, rd_mem, addr_mem, p0_ack);
    end
  endtask

  task automatic test_tie();
    do_reset();
    @(negedge clk);
    p0_rd = 1'b1; p0_addr = 32'h200;
    p1_wr = 1'b1; p1_addr = 32'h300; p1_data = 32'h55;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    #1;
    checks++;
    if ({wr_mem, rd_mem, addr_mem, data_mem} !== {1'b1, 1'b0, 32'h300, 32'h55}) begin
      errors++; $display("FAIL tie_first_req: wr=%b rd=%b addr=%h data=%h required 1 0 00000300 00000055", wr_mem, rd_mem, addr_mem, data_mem);
    end
    checks++;
    if ({p1_ack, p1_rdata, p0_ack} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL tie_first_ack: ack1=%b data1=%h ack0=%b required 1 00000000 0", p1_ack, p1_rdata, p0_ack);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({busy, rd_mem, wr_mem} !== 3'b000) begin
      errors++; $display("FAIL tie_gap: busy=%b rd=%b wr=%b required 0 0 0", busy, rd_mem, wr_mem);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    checks++;
    if ({rd_mem, wr_mem, addr_mem, p0_ack, p0_rdata} !== {1'b1, 1'b0, 32'h200, 1'b1, 32'h1234_5678}) begin
      errors++; $display("FAIL tie_second: rd=%b wr=%b addr=%h ack0=%b data0=%h required 1 0 00000200 1 12345678",
                         rd_mem, wr_mem, addr_mem, p0_ack, p0_rdata);
    end
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    int w;
    logic [31:0] exp_addr;
    do_reset();
    @(negedge clk);
    p0_rd = 1'b1; p0_addr = 32'h1000;
    p1_rd = 1'b1; p1_addr = 32'h2000;
    @(negedge clk);
    clear_inputs();
    #1;
    for (int t = 0; t < 6; t++) begin
      w = 0;
      while (!rd_mem && w < 8) begin
        @(negedge clk); #1; w++;
      end
      exp_addr = (t % 2 == 0) ? 32'h2000 : 32'h1000;
      checks++;
      if (!rd_mem || addr_mem !== exp_addr) begin
        errors++; $display("FAIL b2b_grant_%0d: rd=%b addr=%h required 1 %h", t, rd_mem, addr_mem, exp_addr);
      end
      mem_ack = 1'b1; mem_rdata = $urandom;
      if (t % 2 == 0) p1_rd = 1'b1; else p0_rd = 1'b1;
      #1;
      checks++;
      if ({p1_ack, p0_ack} !== ((t % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL b2b_ack_%0d: ack1=%b ack0=%b required %0d", t, p1_ack, p0_ack, (t % 2 == 0) ? 1 : 0);
      end
      @(negedge clk);
      clear_inputs();
      #1;
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    @(negedge clk);
    p1_wr = 1'b1; p1_addr = 32'h380; p1_data = 32'hAA;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    #1;
    checks++;
    if ({wr_mem, addr_mem, data_mem} !== {1'b1, 32'h380, 32'hAA}) begin
      errors++; $display("FAIL setwins_wr: wr=%b addr=%h data=%h required 1 00000380 000000aa", wr_mem, addr_mem, data_mem);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1111;
    p1_rd = 1'b1; p1_addr = 32'h400;
    #1;
    checks++;
    if ({p1_ack, p1_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL setwins_ack_wr: ack1=%b data1=%h required 1 00000000", p1_ack, p1_rdata);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if ({busy, rd_mem, wr_mem} !== 3'b000) begin
      errors++; $display("FAIL setwins_gap: busy=%b rd=%b wr=%b required 0 0 0", busy, rd_mem, wr_mem);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hBEEF;
    #1;
    checks++;
    if ({rd_mem, wr_mem, addr_mem, p1_ack, p1_rdata} !== {1'b1, 1'b0, 32'h400, 1'b1, 32'hBEEF}) begin
      errors++; $display("FAIL setwins_rd: rd=%b wr=%b addr=%h ack1=%b data1=%h required 1 0 00000400 1 0000beef",
                         rd_mem, wr_mem, addr_mem, p1_ack, p1_rdata);
    end
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_busy();
    do_reset();
    @(negedge clk);
    p0_rd = 1'b1; p0_addr = 32'h500;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    #1;
    checks++;
    if ({busy, rd_mem} !== 2'b11) begin
      errors++; $display("FAIL rstbusy_pre: busy=%b rd=%b required 1 1", busy, rd_mem);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h77;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, rd_mem, wr_mem, addr_mem, data_mem, p0_ack, p0_rdata, p1_ack, p1_rdata} !== '0) begin
      errors++; $display("FAIL rstbusy_async: busy=%b rd=%b addr=%h ack0=%b data0=%h required all 0",
                         busy, rd_mem, addr_mem, p0_ack, p0_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_ack = k[0];
      #1;
      checks++;
      if ({p0_ack, busy} !== 2'b00) begin
        errors++; $display("FAIL rstbusy_noack_%0d: ack0=%b busy=%b required 0 0", k, p0_ack, busy);
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    p1_rd = 1'b1; p1_addr = 32'h600;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h66;
    #1;
    checks++;
    if ({rd_mem, addr_mem, p1_ack, p1_rdata, p0_ack} !== {1'b1, 32'h600, 1'b1, 32'h66, 1'b0}) begin
      errors++; $display("FAIL rstbusy_next: rd=%b addr=%h ack1=%b data1=%h ack0=%b required 1 00000600 1 00000066 0",
                         rd_mem, addr_mem, p1_ack, p1_rdata, p0_ack);
    end
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int w;
    do_reset();
    @(negedge clk);
    p0_rd = 1'b1; p0_addr = 32'h700;
    @(negedge clk);
    clear_inputs();
    n = 0;
    w = 0;
    #1;
    while (!p0_ack && w < 400) begin
      @(negedge clk); #1; w++;
      if (rd_mem) n++;
    end
    checks++;
    if ({p0_ack, p0_rdata, err} !== {1'b1, 32'h0, 1'b1} || n != 255) begin
      errors++; $display("FAIL timeout_abort: ack0=%b data0=%h err=%b busy_cycles=%0d required 1 00000000 1 255",
                         p0_ack, p0_rdata, err, n);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({err, busy} !== 2'b10) begin
      errors++; $display("FAIL timeout_sticky: err=%b busy=%b required 1 0", err, busy);
    end
    do_reset();
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: err=%b required 0", err);
    end
  endtask
`endif

  // Transaction-level model: each cache holds at most one outstanding request;
  // memory serves eligible requests (pulsed >= 2 cycles earlier, >= 2 cycles after
  // the previous completion), preferring the port not served last on a tie.
  task automatic test_random();
    bit          ov [2];
    logic [31:0] oa [2];
    logic [31:0] od [2];
    bit          ow [2];
    int          oc [2];
    bit          np [2];
    bit          prd [2];
    bit          pwr [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    int          last_srv = 0;
    int          last_ack = -10;
    bit          mb = 1'b0;
    int          cur = 0;
    int          ack_at = 0;
    bit          ack;
    bit          e0, e1;
    logic [31:0] rdata;
    logic [31:0] mask;
    int          r;
    int          kind;
    do_reset();
    for (int p = 0; p < 2; p++) begin ov[p] = 1'b0; oc[p] = 0; end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!mb) begin
        e0 = ov[0] && (oc[0] <= c - 2);
        e1 = ov[1] && (oc[1] <= c - 2);
        if ((e0 || e1) && c >= last_ack + 2) begin
          cur    = (e0 && e1) ? (1 - last_srv) : (e1 ? 1 : 0);
          mb     = 1'b1;
          ack_at = c + $urandom_range(0, 3);
        end
      end
      checks++;
      if (mb) begin
        mask = ow[cur] ? 32'hFFFF_FFFF : 32'h0;
        if ({busy, rd_mem, wr_mem, addr_mem, data_mem & mask} !== {1'b1, !ow[cur], ow[cur], oa[cur], od[cur] & mask}) begin
          errors++; $display("FAIL rand_req c=%0d: busy=%b rd=%b wr=%b addr=%h data=%h required port%0d 1 %b %b %h %h",
                             c, busy, rd_mem, wr_mem, addr_mem, data_mem, cur, !ow[cur], ow[cur], oa[cur], od[cur]);
        end
      end else begin
        if ({busy, rd_mem, wr_mem, addr_mem, data_mem} !== '0) begin
          errors++; $display("FAIL rand_idle c=%0d: busy=%b rd=%b wr=%b addr=%h data=%h required all 0",
                             c, busy, rd_mem, wr_mem, addr_mem, data_mem);
        end
      end
      ack   = mb && (c == ack_at);
      rdata = $urandom;
      mem_ack   = ack ? 1'b1 : (!mb && $urandom_range(0, 7) == 0);
      mem_rdata = rdata;
      for (int p = 0; p < 2; p++) begin
        np[p] = 1'b0; prd[p] = 1'b0; pwr[p] = 1'b0;
        pa[p] = $urandom; pd[p] = $urandom;
        r = $urandom_range(0, 99);
        if (!ov[p] || (ack && cur == p)) begin
          if (r < 35) begin
            kind   = $urandom_range(0, 2);
            np[p]  = 1'b1;
            prd[p] = (kind != 1);
            pwr[p] = (kind != 0);
          end
        end else if (r < 5) begin
          prd[p] = 1'b1;
        end
      end
      p0_rd = prd[0]; p0_wr = pwr[0]; p0_addr = pa[0]; p0_data = pd[0];
      p1_rd = prd[1]; p1_wr = pwr[1]; p1_addr = pa[1]; p1_data = pd[1];
      #1;
      checks++;
      if ({p0_ack, p0_rdata} !== {ack && cur == 0, (ack && cur == 0 && !ow[0]) ? rdata : 32'h0}) begin
        errors++; $display("FAIL rand_ack0 c=%0d: ack=%b data=%h required %b", c, p0_ack, p0_rdata, ack && cur == 0);
      end
      checks++;
      if ({p1_ack, p1_rdata, err} !== {ack && cur == 1, (ack && cur == 1 && !ow[1]) ? rdata : 32'h0, 1'b0}) begin
        errors++; $display("FAIL rand_ack1 c=%0d: ack=%b data=%h err=%b required %b", c, p1_ack, p1_rdata, err, ack && cur == 1);
      end
      if (ack) begin
        ov[cur]  = 1'b0;
        last_srv = cur;
        last_ack = c;
        mb       = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (np[p]) begin
          ov[p] = 1'b1; oa[p] = pa[p]; od[p] = pd[p]; ow[p] = pwr[p]; oc[p] = c;
        end
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_set_wins();
    test_reset_busy();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
